// File: rtl/fetch_inst_queue_if.sv
// Handshake bundle between the fetch stage, the instruction queue and dual-issue decode.
// The queue side uses the slave modport; the driving environment uses master.
interface fetch_inst_queue_if #(
  parameter int PTR_W = 4
);
  logic             flush;
  logic             in_valid_1;
  logic [31:0]      in_pc_1;
  logic [31:0]      in_inst_1;
  logic             in_valid_2;
  logic [31:0]      in_pc_2;
  logic [31:0]      in_inst_2;
  logic             full;
  logic             out_valid_1;
  logic [31:0]      out_pc_1;
  logic [31:0]      out_inst_1;
  logic             out_valid_2;
  logic [31:0]      out_pc_2;
  logic [31:0]      out_inst_2;
  logic             out_ready_1;
  logic             out_ready_2;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid_1, in_pc_1, in_inst_1, in_valid_2, in_pc_2, in_inst_2,
    output out_ready_1, out_ready_2,
    input  full, out_valid_1, out_pc_1, out_inst_1, out_valid_2, out_pc_2, out_inst_2, count
  );

  modport slave (
    input  flush, in_valid_1, in_pc_1, in_inst_1, in_valid_2, in_pc_2, in_inst_2,
    input  out_ready_1, out_ready_2,
    output full, out_valid_1, out_pc_1, out_inst_1, out_valid_2, out_pc_2, out_inst_2, count
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Two-in/two-out circular instruction queue between fetch and dual-issue decode.
// Optional same-cycle empty-queue bypass is enabled by defining INSTQ_BYPASS_EN.
module fetch_inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  fetch_inst_queue_if.slave q
);
  localparam logic [PTR_W:0] FULL_LIMIT = (PTR_W+1)'(DEPTH - 2);

  // Pointers carry one extra bit so that full (count=DEPTH) and empty differ.
  logic [PTR_W:0]   r_head;
  logic [PTR_W:0]   r_tail;
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];

  logic [PTR_W:0]   w_count;
  logic             w_full;
  logic [PTR_W-1:0] w_tail_idx;
  logic [PTR_W-1:0] w_tail_idx_1;
  logic             w_wr_1;
  logic             w_wr_2;
  logic [1:0]       w_nwr;
  logic [1:0]       w_nrd;

  logic [1:0]       w_stored_valid;
  logic [31:0]      w_stored_pc   [2];
  logic [31:0]      w_stored_inst [2];
  logic [1:0]       w_slot_valid;
  logic [31:0]      w_slot_pc     [2];
  logic [31:0]      w_slot_inst   [2];

  assign w_count      = r_tail - r_head;
  assign w_full       = (w_count > FULL_LIMIT);
  assign w_tail_idx   = r_tail[PTR_W-1:0];
  assign w_tail_idx_1 = w_tail_idx + PTR_W'(1);

  // Full is judged on registered occupancy only; a same-cycle pop does not rescue a write.
  assign w_wr_1 = q.in_valid_1 & ~w_full & ~q.flush;
  assign w_wr_2 = w_wr_1 & q.in_valid_2;
  assign w_nwr  = 2'(w_wr_1) + 2'(w_wr_2);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [PTR_W-1:0] w_idx;
    assign w_idx              = r_head[PTR_W-1:0] + PTR_W'(gi);
    assign w_stored_valid[gi] = (w_count > (PTR_W+1)'(gi));
    assign w_stored_pc[gi]    = r_pc[w_idx];
    assign w_stored_inst[gi]  = r_inst[w_idx];
  end

  always_comb begin
    w_slot_valid = w_stored_valid;
    w_slot_pc    = w_stored_pc;
    w_slot_inst  = w_stored_inst;
`ifdef INSTQ_BYPASS_EN
    // Empty queue: present fetch data directly; consumed entries still advance head past them.
    if (w_count == '0 && !q.flush) begin
      w_slot_valid   = {q.in_valid_1 & q.in_valid_2, q.in_valid_1};
      w_slot_pc[0]   = q.in_pc_1;
      w_slot_pc[1]   = q.in_pc_2;
      w_slot_inst[0] = q.in_inst_1;
      w_slot_inst[1] = q.in_inst_2;
    end
`endif
  end

  assign w_nrd = 2'(q.out_ready_1 & w_slot_valid[0])
               + 2'(q.out_ready_1 & q.out_ready_2 & w_slot_valid[1]);

  always_ff @(posedge clk) begin
    if (!resetn || q.flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + (PTR_W+1)'(w_nrd);
      r_tail <= r_tail + (PTR_W+1)'(w_nwr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_1) begin
      r_pc[w_tail_idx]   <= q.in_pc_1;
      r_inst[w_tail_idx] <= q.in_inst_1;
    end
    if (w_wr_2) begin
      r_pc[w_tail_idx_1]   <= q.in_pc_2;
      r_inst[w_tail_idx_1] <= q.in_inst_2;
    end
  end

  assign q.count       = w_count;
  assign q.full        = w_full;
  assign q.out_valid_1 = w_slot_valid[0];
  assign q.out_valid_2 = w_slot_valid[1];
  assign q.out_pc_1    = w_slot_valid[0] ? w_slot_pc[0]   : 32'h0;
  assign q.out_inst_1  = w_slot_valid[0] ? w_slot_inst[0] : 32'h0;
  assign q.out_pc_2    = w_slot_valid[1] ? w_slot_pc[1]   : 32'h0;
  assign q.out_inst_2  = w_slot_valid[1] ? w_slot_inst[1] : 32'h0;
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_inst_queue;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_inst_queue_if #(.PTR_W(PTR_W)) bus();

  fetch_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        flush, v1, v2, r1, r2;
    logic [31:0] pc;
    int          exp_count;
    logic        exp_full, exp_v1, exp_v2;
    logic [31:0] exp_pc1, exp_pc2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_state(input string name, input int cnt, input logic fl,
                             input logic v1, input logic v2,
                             input logic [31:0] pc1, input logic [31:0] pc2);
    check({name, " count"}, 32'(bus.count), 32'(cnt));
    check({name, " full"}, 32'(bus.full), 32'(fl));
    check({name, " out_valid_1"}, 32'(bus.out_valid_1), 32'(v1));
    check({name, " out_valid_2"}, 32'(bus.out_valid_2), 32'(v2));
    check({name, " out_pc_1"}, bus.out_pc_1, pc1);
    check({name, " out_pc_2"}, bus.out_pc_2, pc2);
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.in_valid_1 = 1'b0; bus.in_pc_1 = '0; bus.in_inst_1 = '0;
    bus.in_valid_2 = 1'b0; bus.in_pc_2 = '0; bus.in_inst_2 = '0;
    bus.out_ready_1 = 1'b0; bus.out_ready_2 = 1'b0;
  endtask

  task automatic drive_wr(input logic v1, input logic v2, input logic [31:0] pc);
    bus.in_valid_1 = v1; bus.in_pc_1 = pc;        bus.in_inst_1 = ~pc;
    bus.in_valid_2 = v2; bus.in_pc_2 = pc + 32'd4; bus.in_inst_2 = ~(pc + 32'd4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    tick();
    resetn = 1'b1;
  endtask

  logic [63:0] mq[$];

  initial begin
    idle();
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC00000, 2, 1'b0, 1'b1, 1'b1, 32'hBFC00000, 32'hBFC00004};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000,     1, 1'b0, 1'b1, 1'b0, 32'h1000,     32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000,     1, 1'b0, 1'b1, 1'b0, 32'h1000,     32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1, 1'b0, 1'b1, 1'b0, 32'h1000,     32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000,     2, 1'b0, 1'b1, 1'b1, 32'h3000,     32'h3004};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4000,     0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5000,     2, 1'b0, 1'b1, 1'b1, 32'h5000,     32'h5004};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1, 1'b0, 1'b1, 1'b0, 32'h5004,     32'h0};

    // Reset state
    do_reset();
    check_state("reset", 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("reset: count=%0d full=%0b", bus.count, bus.full);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      drive_wr(vecs[i].v1, vecs[i].v2, vecs[i].pc);
      bus.flush = vecs[i].flush;
      bus.out_ready_1 = vecs[i].r1;
      bus.out_ready_2 = vecs[i].r2;
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_full,
                  vecs[i].exp_v1, vecs[i].exp_v2, vecs[i].exp_pc1, vecs[i].exp_pc2);
      $display("vec%0d: flush=%0b v=%0b%0b r=%0b%0b -> count=%0d pc1=%08h",
               i, vecs[i].flush, vecs[i].v1, vecs[i].v2, vecs[i].r1, vecs[i].r2,
               bus.count, bus.out_pc_1);
    end

    // Fill to full, dropped writes, dropped write despite same-cycle pop
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_wr(1'b1, 1'b1, 32'h8000 + 32'(8 * k));
      tick();
    end
    check_state("fill14", 14, 1'b0, 1'b1, 1'b1, 32'h8000, 32'h8004);
    drive_wr(1'b1, 1'b1, 32'h9000);
    tick();
    check_state("fill16", 16, 1'b1, 1'b1, 1'b1, 32'h8000, 32'h8004);
    drive_wr(1'b1, 1'b1, 32'hA000);
    tick();
    check_state("full_drop", 16, 1'b1, 1'b1, 1'b1, 32'h8000, 32'h8004);
    drive_wr(1'b1, 1'b1, 32'hB000);
    bus.out_ready_1 = 1'b1;
    tick();
    check_state("full_drop_pop", 15, 1'b1, 1'b1, 1'b1, 32'h8004, 32'h8008);
    $display("fill: count=%0d full=%0b", bus.count, bus.full);

    // Simultaneous write/read at count 5, then flush priority at count 8
    do_reset();
    drive_wr(1'b1, 1'b1, 32'h600); tick();
    drive_wr(1'b1, 1'b1, 32'h608); tick();
    drive_wr(1'b1, 1'b0, 32'h610); tick();
    check("simul pre count", 32'(bus.count), 32'd5);
    drive_wr(1'b1, 1'b1, 32'h700);
    bus.out_ready_1 = 1'b1;
    tick();
    check_state("simul", 6, 1'b0, 1'b1, 1'b1, 32'h604, 32'h608);
    drive_wr(1'b1, 1'b1, 32'h720); tick();
    check("flush pre count", 32'(bus.count), 32'd8);
    drive_wr(1'b1, 1'b1, 32'h740);
    bus.flush = 1'b1; bus.out_ready_1 = 1'b1; bus.out_ready_2 = 1'b1;
    tick();
    check_state("flush", 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("simul/flush: count=%0d", bus.count);

    // Wrap: bring head and tail to index 15, then straddle the wrap
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_wr(1'b1, 1'b1, 32'h2000 + 32'(8 * k)); tick();
    end
    drive_wr(1'b1, 1'b0, 32'h2100); tick();
    for (int k = 0; k < 7; k++) begin
      bus.out_ready_1 = 1'b1; bus.out_ready_2 = 1'b1; tick();
    end
    bus.out_ready_1 = 1'b1; tick();
    check("wrap drained", 32'(bus.count), 32'd0);
    drive_wr(1'b1, 1'b1, 32'h100); tick();
    check_state("wrap write", 2, 1'b0, 1'b1, 1'b1, 32'h100, 32'h104);
    check("wrap inst1", bus.out_inst_1, ~32'h100);
    check("wrap inst2", bus.out_inst_2, ~32'h104);
    bus.out_ready_1 = 1'b1; bus.out_ready_2 = 1'b1; tick();
    check_state("wrap read", 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("wrap: count=%0d", bus.count);

    // Randomized run against the queue model
    do_reset();
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int n, nrd, rd_bias;
      logic v1, v2, r1, r2, fl, rn;
      logic e_v1, e_v2, full_pre;
      logic [31:0] e_pc1, e_in1, e_pc2, e_in2;
      logic [31:0] p1, i1, p2, i2;

      rd_bias = ((cyc / 200) % 2 == 1) ? 3 : 1;
      rn = ($urandom_range(0, 199) != 0);
      fl = ($urandom_range(0, 39) == 0);
      v1 = ($urandom_range(0, 3) != 0);
      v2 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 3) < rd_bias);
      r2 = ($urandom_range(0, 1) == 1);
      p1 = $urandom; i1 = $urandom; p2 = $urandom; i2 = $urandom;

      resetn = rn; bus.flush = fl;
      bus.in_valid_1 = v1; bus.in_pc_1 = p1; bus.in_inst_1 = i1;
      bus.in_valid_2 = v2; bus.in_pc_2 = p2; bus.in_inst_2 = i2;
      bus.out_ready_1 = r1; bus.out_ready_2 = r2;
      #1;

      n = mq.size();
      e_v1 = (n >= 1); e_v2 = (n >= 2);
      e_pc1 = '0; e_in1 = '0; e_pc2 = '0; e_in2 = '0;
      if (n >= 1) begin e_pc1 = mq[0][63:32]; e_in1 = mq[0][31:0]; end
      if (n >= 2) begin e_pc2 = mq[1][63:32]; e_in2 = mq[1][31:0]; end
`ifdef INSTQ_BYPASS_EN
      if (n == 0 && !fl) begin
        e_v1 = v1; e_v2 = v1 & v2;
        e_pc1 = e_v1 ? p1 : '0; e_in1 = e_v1 ? i1 : '0;
        e_pc2 = e_v2 ? p2 : '0; e_in2 = e_v2 ? i2 : '0;
      end
`endif
      full_pre = (n > DEPTH - 2);
      check("rnd count", 32'(bus.count), 32'(n));
      check("rnd full", 32'(bus.full), 32'(full_pre));
      check("rnd out_valid_1", 32'(bus.out_valid_1), 32'(e_v1));
      check("rnd out_valid_2", 32'(bus.out_valid_2), 32'(e_v2));
      check("rnd out_pc_1", bus.out_pc_1, e_pc1);
      check("rnd out_inst_1", bus.out_inst_1, e_in1);
      check("rnd out_pc_2", bus.out_pc_2, e_pc2);
      check("rnd out_inst_2", bus.out_inst_2, e_in2);

      nrd = int'(r1 & e_v1) + int'(r1 & r2 & e_v2);
      if (!rn || fl) begin
        mq.delete();
      end else begin
        if (!full_pre && v1) begin
          mq.push_back({p1, i1});
          if (v2) mq.push_back({p2, i2});
        end
        for (int k = 0; k < nrd; k++) void'(mq.pop_front());
      end
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    idle();
    $display("random: 3000 cycles, final count=%0d", bus.count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction buffer between the fetch PC/I-cache stage and dual-issue decode.
- Accepts 0–2 fetched instructions per cycle, each with its PC, and presents up to 2 in program order to decode.
- Drives `full` back to the fetch PC generator, which holds the PC while `full` is asserted.
- Flushed on branch redirect or exception.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- flush  input  1  discard all entries (branch/exception redirect)
- in_valid_1  input  1  fetch slot 1 valid
- in_pc_1  input  32  PC of slot 1
- in_inst_1  input  32  instruction of slot 1
- in_valid_2  input  1  fetch slot 2 valid; legal only with in_valid_1
- in_pc_2  input  32  PC of slot 2
- in_inst_2  input  32  instruction of slot 2
- full  output  1  fewer than 2 free entries
- out_valid_1  output  1  decode slot 1 holds an instruction
- out_pc_1  output  32  PC of oldest entry
- out_inst_1  output  32  oldest instruction
- out_valid_2  output  1  decode slot 2 holds an instruction
- out_pc_2  output  32  PC of second-oldest entry
- out_inst_2  output  32  second-oldest instruction
- out_ready_1  input  1  decode consumes slot 1 this cycle
- out_ready_2  input  1  decode consumes slot 2; effective only with out_ready_1
- count  output  PTR_W+1  current occupancy

Behaviour:
- Storage: circular register array of {pc, inst}. Head and tail pointers are PTR_W+1 bits and wrap modulo 2*DEPTH; the index is the low PTR_W bits.
- count = tail - head, range 0..DEPTH.
- full = (count > DEPTH-2), combinational from registered state.
- Write acceptance:
  - Writes are accepted only when full=0. When full=1 the write is dropped and the pointers do not move.
  - nwr = in_valid_1 + (in_valid_1 & in_valid_2).
  - in_valid_2 without in_valid_1 is ignored.
  - Slot 1 is written at tail, slot 2 at tail+1.
- Outputs:
  - out_valid_1 = (count >= 1); out_valid_2 = (count >= 2).
  - Data is read from head and head+1.
  - pc/inst outputs are forced to 0 when the corresponding valid is 0.
- Reads:
  - nrd = (out_ready_1 & out_valid_1) + (out_ready_1 & out_ready_2 & out_valid_2).
  - out_ready_2 alone pops nothing; decode consumes strictly in order.
- Update each clock: head += nrd, tail += nwr.
  - Simultaneous read and write is supported; the net count change is nwr - nrd.
  - A write while full=1 is dropped even if a read frees space in the same cycle.
- Latency: an instruction written in cycle N is visible on the outputs at cycle N+1 (see optional feature).
- Flush:
  - On the next edge, head = tail = 0.
  - Takes priority over same-cycle writes and reads; those are discarded.
  - out_valid_* are 0 in the cycle after flush.
- Reset (resetn=0 at an edge): head = tail = 0. This gives full=0, count=0, out_valid_*=0 and out_pc/inst=0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries.
- Wrap-around: pointer wrap at index DEPTH-1→0 is seamless, including a 2-entry write or read that straddles the wrap.

Optional Feature:
- Macro: INSTQ_BYPASS_EN.
- Defined, queue empty (count=0), no flush:
  - in_valid_1/in_valid_2 and their pc/inst drive out_valid_*/out_pc_*/out_inst_* combinationally in the same cycle.
  - Bypassed instructions consumed by out_ready_* that cycle are not stored.
  - Unconsumed ones are written normally.
- Undefined: outputs come only from storage; latency is strictly 1 cycle.

Test Plan:
- Reset then empty: resetn=0 one edge → count=0, full=0, out_valid_1=out_valid_2=0, out_pc_1=0.
- Dual write/dual read: write {0xBFC00000, 0xBFC00004} with out_ready=0 → next cycle count=2, out_pc_1=0xBFC00000, out_pc_2=0xBFC00004. Then out_ready_1=out_ready_2=1 → count=0.
- Fill to full (DEPTH=16): 7 dual writes with no reads → count=14, full=0. One more dual write → count=16, full=1. A further write → dropped, count stays 16.
- Simultaneous: count=5, dual write plus single read (out_ready_1=1, out_ready_2=0) → count=6, and the new head is the old entry 1.
- Flush priority: count=8, flush=1 with a dual write and dual read in the same cycle → next cycle count=0, out_valid_1=0.
- Wrap: advance head/tail to index 15, then dual write {0x100, 0x104} → entries land at index 15 and index 0; dual read returns 0x100 then 0x104 in order.
